// File: rtl/aurora_8b10b_pkg.sv
// Shared symbol codes and scheduler state encoding for the Aurora 8b/10b transmit lane.
package aurora_8b10b_pkg;

  localparam logic [7:0] K_IDLE = 8'hBC;
  localparam logic [7:0] K_SOF  = 8'hFB;
  localparam logic [7:0] K_EOF  = 8'hFD;
  localparam logic [7:0] K_CC   = 8'hF7;

  typedef enum logic [2:0] {
    OFF  = 3'd0,
    INIT = 3'd1,
    IDLE = 3'd2,
    SOF  = 3'd3,
    DATA = 3'd4,
    EOF  = 3'd5,
    CC   = 3'd6
  } tx_state_t;

endpackage

// File: rtl/aurora_cc_timer.sv
// Clock-compensation period timer: free-running while enabled, raises pend on every wrap
// and holds it until the scheduler reports the burst finished.
module aurora_cc_timer #(
  parameter int unsigned CC_PERIOD = 5000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run,
  input  logic clr,
  output logic pend
);

  localparam int unsigned    CW       = (CC_PERIOD > 1) ? $clog2(CC_PERIOD) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(CC_PERIOD - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  logic [CW-1:0] cnt_r;
  logic          pend_r;
  logic          wrap_s;

  assign wrap_s = run && (cnt_r == CNT_LAST);
  assign pend   = pend_r;

  // Period counter and sticky request; a wrap coinciding with clr wins so it is not lost
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_r  <= '0;
      pend_r <= 1'b0;
    end else begin
      if (wrap_s) begin
        cnt_r <= '0;
      end else if (run) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
      if (wrap_s) begin
        pend_r <= 1'b1;
      end else if (clr) begin
        pend_r <= 1'b0;
      end else begin
        pend_r <= pend_r;
      end
    end
  end

endmodule

// File: rtl/aurora_tx_scheduler.sv
// Aurora 8b/10b transmit symbol scheduler feeding a combinational encoder (no output register).
// Optional build macro AURORA_TX_STATS_EN adds frame_cnt_o / cc_cnt_o statistics ports.
module aurora_tx_scheduler
  import aurora_8b10b_pkg::*;
#(
  parameter int unsigned INIT_LEN  = 16,
  parameter int unsigned CC_PERIOD = 5000,
  parameter int unsigned CC_LEN    = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        link_en_i,
  input  logic [7:0]  s_tdata_i,
  input  logic        s_tvalid_i,
  input  logic        s_tlast_i,
  output logic        s_tready_o,
  output logic [7:0]  enc_data_o,
  output logic        enc_ctrl_o,
  output logic        enc_disp_o,
  input  logic        enc_disp_i,
  output logic        busy_o
`ifdef AURORA_TX_STATS_EN
  ,
  output logic [15:0] frame_cnt_o,
  output logic [15:0] cc_cnt_o
`endif
);

  localparam int unsigned    IW        = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;
  localparam logic [IW-1:0]  INIT_LAST = IW'(INIT_LEN - 1);
  localparam logic [IW-1:0]  INIT_ONE  = IW'(1);
  localparam int unsigned    BW        = (CC_LEN > 1) ? $clog2(CC_LEN) : 1;
  localparam logic [BW-1:0]  CC_LAST   = BW'(CC_LEN - 1);
  localparam logic [BW-1:0]  CC_ONE    = BW'(1);

  tx_state_t     state_r, state_s, ret_r, ret_s;
  logic [IW-1:0] init_cnt_r, init_cnt_s;
  logic [BW-1:0] burst_cnt_r, burst_cnt_s;
  logic [7:0]    data_r, sym_s;
  logic          ctrl_r, ctrl_s;
  logic          rd_r;
  logic          cc_pend_s, clr_s, cc_go_s, run_s;

  assign run_s = (state_r != OFF) && (state_r != INIT);

  aurora_cc_timer #(.CC_PERIOD(CC_PERIOD)) u_cc_timer (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .run   (run_s),
    .clr   (clr_s),
    .pend  (cc_pend_s)
  );

  // Next state and symbol choice; the cycle that sees cc_pend already emits the first K23.7
  always_comb begin
    state_s     = state_r;
    ret_s       = ret_r;
    init_cnt_s  = init_cnt_r;
    burst_cnt_s = burst_cnt_r;
    sym_s       = K_IDLE;
    ctrl_s      = 1'b1;
    clr_s       = 1'b0;
    cc_go_s     = 1'b0;
    if (!link_en_i) begin
      state_s = OFF;
    end else begin
      case (state_r)
        OFF: begin
          state_s    = INIT;
          init_cnt_s = '0;
        end
        INIT: begin
          if (init_cnt_r == INIT_LAST) begin
            state_s    = IDLE;
            init_cnt_s = '0;
          end else begin
            init_cnt_s = init_cnt_r + INIT_ONE;
          end
        end
        IDLE: begin
          if (cc_pend_s) begin
            cc_go_s = 1'b1;
          end else if (s_tvalid_i) begin
            state_s = SOF;
          end else begin
            state_s = IDLE;
          end
        end
        SOF: begin
          sym_s   = K_SOF;
          state_s = DATA;
        end
        DATA: begin
          if (cc_pend_s) begin
            cc_go_s = 1'b1;
          end else if (s_tvalid_i) begin
            sym_s  = s_tdata_i;
            ctrl_s = 1'b0;
            if (s_tlast_i) begin
              state_s = EOF;
            end else begin
              state_s = DATA;
            end
          end else begin
            state_s = DATA;
          end
        end
        EOF: begin
          sym_s   = K_EOF;
          state_s = IDLE;
        end
        CC: begin
          sym_s = K_CC;
          if (burst_cnt_r == CC_LAST) begin
            clr_s       = 1'b1;
            state_s     = ret_r;
            burst_cnt_s = '0;
          end else begin
            burst_cnt_s = burst_cnt_r + CC_ONE;
          end
        end
        default: begin
          state_s = OFF;
        end
      endcase
      if (cc_go_s) begin
        sym_s = K_CC;
        ret_s = state_r;
        if (CC_LEN == 1) begin
          clr_s = 1'b1;
        end else begin
          state_s     = CC;
          burst_cnt_s = CC_ONE;
        end
      end else begin
        ret_s = ret_r;
      end
    end
  end

  // State, counters, encoder input register and running-disparity loop register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= OFF;
      ret_r       <= IDLE;
      init_cnt_r  <= '0;
      burst_cnt_r <= '0;
      data_r      <= K_IDLE;
      ctrl_r      <= 1'b1;
      rd_r        <= 1'b0;
    end else begin
      state_r     <= state_s;
      ret_r       <= ret_s;
      init_cnt_r  <= init_cnt_s;
      burst_cnt_r <= burst_cnt_s;
      data_r      <= sym_s;
      ctrl_r      <= ctrl_s;
      rd_r        <= enc_disp_i;
    end
  end

  assign enc_data_o = data_r;
  assign enc_ctrl_o = ctrl_r;
  assign enc_disp_o = rd_r;
  assign s_tready_o = (state_r == DATA) && !cc_pend_s;
  assign busy_o     = (state_r == SOF) || (state_r == DATA) || (state_r == EOF) ||
                      ((state_r == CC) && (ret_r == DATA));

`ifdef AURORA_TX_STATS_EN
  logic [15:0] frame_cnt_r, cc_cnt_r;

  // Frame and CC-burst statistics, both wrapping naturally at 16 bits
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_cnt_r <= 16'd0;
      cc_cnt_r    <= 16'd0;
    end else begin
      if (link_en_i && (state_r == EOF)) begin
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end else begin
        frame_cnt_r <= frame_cnt_r;
      end
      if (clr_s) begin
        cc_cnt_r <= cc_cnt_r + 16'd1;
      end else begin
        cc_cnt_r <= cc_cnt_r;
      end
    end
  end

  assign frame_cnt_o = frame_cnt_r;
  assign cc_cnt_o    = cc_cnt_r;
`endif

endmodule

// File: tb/tb_aurora_tx_scheduler.sv
// Self-checking bench for aurora_tx_scheduler: vector table, hand-built streaming sequence,
// and randomized frames against a behavioural lane model closing the disparity loop.
module tb_aurora_tx_scheduler;

  localparam int INIT_LEN  = 16;
  localparam int CC_PERIOD = 20;
  localparam int CC_LEN    = 4;

  logic       clk_i = 1'b0;
  logic       rst_i, link_en_i, s_tvalid_i, s_tlast_i;
  logic [7:0] s_tdata_i;
  logic       s_tready_o, enc_ctrl_o, enc_disp_o, enc_disp_i, busy_o;
  logic [7:0] enc_data_o;
`ifdef AURORA_TX_STATS_EN
  logic [15:0] frame_cnt_o, cc_cnt_o;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  aurora_tx_scheduler #(.INIT_LEN(INIT_LEN), .CC_PERIOD(CC_PERIOD), .CC_LEN(CC_LEN)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .link_en_i  (link_en_i),
    .s_tdata_i  (s_tdata_i),
    .s_tvalid_i (s_tvalid_i),
    .s_tlast_i  (s_tlast_i),
    .s_tready_o (s_tready_o),
    .enc_data_o (enc_data_o),
    .enc_ctrl_o (enc_ctrl_o),
    .enc_disp_o (enc_disp_o),
    .enc_disp_i (enc_disp_i),
    .busy_o     (busy_o)
`ifdef AURORA_TX_STATS_EN
    ,
    .frame_cnt_o(frame_cnt_o),
    .cc_cnt_o   (cc_cnt_o)
`endif
  );

  // Reference 8b/10b disparity: a symbol flips running disparity iff exactly one sub-block is unbalanced
  function automatic logic sym_flip(input logic [7:0] d, input logic k);
    int  x, y;
    logic u6, u4;
    x  = int'(d[4:0]);
    y  = int'(d[7:5]);
    u6 = (x inside {0, 1, 2, 4, 8, 15, 16, 23, 24, 27, 29, 30, 31}) || (k && x == 28);
    u4 = (y inside {0, 4, 7});
    return u6 ^ u4;
  endfunction

  assign enc_disp_i = enc_disp_o ^ sym_flip(enc_data_o, enc_ctrl_o);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       rst, link, tv, tl;
    logic [7:0] td;
    logic       rdy, busy, k;
    logic [7:0] d;
  } vec_t;
  vec_t tbl[$];

  task automatic add_vec(input logic link, input logic tv, input logic [7:0] td, input logic tl,
                         input logic rdy, input logic busy, input logic [7:0] d, input logic k);
    vec_t v;
    v.rst = 1'b0; v.link = link; v.tv = tv; v.td = td; v.tl = tl;
    v.rdy = rdy; v.busy = busy; v.d = d; v.k = k;
    tbl.push_back(v);
  endtask

  // Behavioural lane model: abstract flags and counters, CC timing from elapsed running cycles
  int         m_linked, m_init_left, m_burst, m_runs, m_served, m_frames_in, m_frames_out;
  bit         m_sof, m_eof, m_open;
  logic [7:0] m_out_d;
  logic       m_out_k, m_rd;

  function automatic bit m_pend();
    return (m_runs / CC_PERIOD) > m_served;
  endfunction
  function automatic bit m_running();
    return (m_linked != 0) && (m_init_left == 0);
  endfunction
  function automatic logic m_rdy();
    return m_running() && m_open && !m_sof && (m_burst == 0) && !m_pend();
  endfunction

  task automatic m_reset();
    m_linked = 0; m_init_left = 0; m_burst = 0; m_runs = 0; m_served = 0; m_frames_out = 0;
    m_sof = 0; m_eof = 0; m_open = 0; m_out_d = 8'hBC; m_out_k = 1'b1; m_rd = 1'b0;
  endtask

  task automatic m_step(input logic rst, input logic link, input logic tv,
                        input logic [7:0] td, input logic tl);
    logic [7:0] nd;
    logic       nk, nrd;
    bit         pend;
    nd = 8'hBC; nk = 1'b1;
    nrd = m_rd ^ sym_flip(m_out_d, m_out_k);
    if (rst) begin
      m_reset();
    end else begin
      pend = m_pend();
      if (m_running()) m_runs++;
      if (!link) begin
        m_linked = 0; m_init_left = 0; m_burst = 0; m_sof = 0; m_eof = 0; m_open = 0;
      end else if (m_linked == 0) begin
        m_linked = 1; m_init_left = INIT_LEN;
      end else if (m_init_left > 0) begin
        m_init_left--;
      end else if (m_burst > 0) begin
        nd = 8'hF7; m_burst--;
        if (m_burst == 0) m_served++;
      end else if (m_sof) begin
        nd = 8'hFB; m_sof = 0;
      end else if (m_eof) begin
        nd = 8'hFD; m_eof = 0; m_frames_out++;
      end else if (pend) begin
        nd = 8'hF7; m_burst = CC_LEN - 1;
        if (m_burst == 0) m_served++;
      end else if (m_open) begin
        if (tv) begin
          nd = td; nk = 1'b0;
          if (tl) begin m_open = 0; m_eof = 1; m_frames_in++; end
        end
      end else if (tv) begin
        m_sof = 1; m_open = 1;
      end
      m_out_d = nd; m_out_k = nk; m_rd = nrd;
    end
  endtask

  logic [7:0] syms[$];
  logic       kq[$], rdyq[$], hsq[$];

  initial begin
    int n_sent, gap_left, first_fb, fd_idx, first_hs, last_hs, n_bc, run, nruns, cyc;
    bit in_gap, rst_done;
    logic [7:0] got[$];

    rst_i = 1'b1; link_en_i = 1'b0; s_tvalid_i = 1'b0; s_tdata_i = 8'h00; s_tlast_i = 1'b0;

    // Reset held with link disabled
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i); #1;
      chk("rst_data", enc_data_o, 8'hBC);
      chk("rst_ctrl", enc_ctrl_o, 1'b1);
      chk("rst_disp", enc_disp_o, 1'b0);
      chk("rst_rdy", s_tready_o, 1'b0);
      chk("rst_busy", busy_o, 1'b0);
    end

    // Table: OFF, INIT of exactly INIT_LEN cycles, then frame 11/22/33
    for (int i = 0; i < 3; i++) add_vec(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hBC, 1'b1);
    add_vec(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hBC, 1'b1);
    for (int i = 0; i < INIT_LEN; i++) add_vec(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hBC, 1'b1);
    add_vec(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hBC, 1'b1);
    add_vec(1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'hBC, 1'b1);
    add_vec(1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 8'hBC, 1'b1);
    add_vec(1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'hFB, 1'b1);
    add_vec(1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0);
    add_vec(1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0);
    add_vec(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0);
    add_vec(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFD, 1'b1);
    add_vec(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hBC, 1'b1);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk_i);
      rst_i = tbl[i].rst; link_en_i = tbl[i].link; s_tvalid_i = tbl[i].tv;
      s_tdata_i = tbl[i].td; s_tlast_i = tbl[i].tl;
      #1;
      chk($sformatf("tbl%0d_rdy", i), s_tready_o, tbl[i].rdy);
      chk($sformatf("tbl%0d_busy", i), busy_o, tbl[i].busy);
      chk($sformatf("tbl%0d_data", i), enc_data_o, tbl[i].d);
      chk($sformatf("tbl%0d_ctrl", i), enc_ctrl_o, tbl[i].k);
    end

    // Long streaming frame with a 2-cycle source gap; CC bursts must cut in without losing bytes
    n_sent = 0; gap_left = 2; cyc = 0;
    while (cyc < 300) begin
      @(negedge clk_i);
      in_gap = (n_sent == 5) && (gap_left > 0);
      s_tvalid_i = (n_sent < 40) && !in_gap;
      s_tdata_i  = 8'h40 + 8'(n_sent);
      s_tlast_i  = (n_sent == 39);
      #1;
      syms.push_back(enc_data_o); kq.push_back(enc_ctrl_o);
      rdyq.push_back(s_tready_o); hsq.push_back(s_tvalid_i && s_tready_o);
      if (in_gap) begin
        chk("gap_busy", busy_o, 1'b1);
        gap_left--;
      end
      if (s_tvalid_i && s_tready_o) n_sent++;
      if (n_sent == 40 && enc_ctrl_o && enc_data_o == 8'hFD) break;
      cyc++;
    end
    chk("stream_timeout", (cyc < 300), 1'b1);
    s_tvalid_i = 1'b0; s_tlast_i = 1'b0;

    first_fb = -1; fd_idx = -1;
    for (int i = 0; i < syms.size(); i++)
      if (first_fb < 0 && kq[i] && syms[i] == 8'hFB) first_fb = i;
    for (int i = first_fb + 1; i < syms.size(); i++)
      if (first_fb >= 0 && fd_idx < 0 && kq[i] && syms[i] == 8'hFD) fd_idx = i;
    chk("stream_sof_eof", (first_fb >= 0) && (fd_idx > first_fb), 1'b1);
    if (first_fb >= 0 && fd_idx > first_fb) begin
      n_bc = 0; run = 0; nruns = 0;
      for (int i = first_fb + 1; i <= fd_idx; i++) begin
        if (kq[i] && syms[i] == 8'hF7) begin
          run++;
        end else begin
          if (run > 0) begin chk("cc_burst_len", run, CC_LEN); nruns++; end
          run = 0;
          if (!kq[i]) got.push_back(syms[i]);
          else if (syms[i] == 8'hBC) n_bc++;
        end
      end
      chk("cc_bursts_seen", (nruns >= 2), 1'b1);
      chk("mid_idle_bc", n_bc, 2);
      chk("stream_count", got.size(), 40);
      for (int i = 0; i < got.size() && i < 40; i++)
        chk($sformatf("stream_byte%0d", i), got[i], 8'h40 + 8'(i));
    end
    first_hs = -1; last_hs = -1;
    for (int i = 0; i < hsq.size(); i++) if (hsq[i]) begin
      if (first_hs < 0) first_hs = i;
      last_hs = i;
    end
    run = 0; nruns = 0;
    for (int i = first_hs + 1; i < last_hs && first_hs >= 0; i++) begin
      if (!rdyq[i]) begin
        run++;
      end else begin
        if (run > 0) begin chk("rdy_low_len", run, CC_LEN); nruns++; end
        run = 0;
      end
    end
    chk("rdy_drops_seen", (nruns >= 2), 1'b1);

    // Randomized frames against the behavioural model, with one reset dropped mid-frame
    m_reset(); m_frames_in = 0; rst_done = 0;
    @(negedge clk_i);
    rst_i = 1'b1; link_en_i = 1'b1; s_tvalid_i = 1'b0;
    m_step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    cyc = 0;
    while (m_frames_in < 1000 && cyc < 60000) begin
      @(negedge clk_i);
      rst_i      = 1'b0;
      s_tvalid_i = ($urandom_range(0, 3) != 0);
      s_tdata_i  = 8'($urandom);
      s_tlast_i  = ($urandom_range(0, 5) == 0);
      if (!rst_done && m_frames_in >= 500 && m_open && !m_sof && m_burst == 0) begin
        rst_i = 1'b1; rst_done = 1;
      end
      #1;
      chk("rnd_rdy", s_tready_o, m_rdy());
      chk("rnd_busy", busy_o, m_open || m_eof);
      chk("rnd_data", enc_data_o, m_out_d);
      chk("rnd_ctrl", enc_ctrl_o, m_out_k);
      chk("rnd_disp", enc_disp_o, m_rd);
`ifdef AURORA_TX_STATS_EN
      chk("rnd_frame_cnt", frame_cnt_o, 16'(m_frames_out));
      chk("rnd_cc_cnt", cc_cnt_o, 16'(m_served));
`endif
      m_step(rst_i, link_en_i, s_tvalid_i, s_tdata_i, s_tlast_i);
      cyc++;
    end
    chk("rnd_frames_done", (m_frames_in >= 1000), 1'b1);
    chk("rnd_reset_applied", rst_done, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aurora_tx_scheduler.md
Name: aurora_tx_scheduler

Overview:
Transmit-side symbol scheduler that sits directly in front of the 8b/10b encoder, with the encoder built with G_OREG = 0.
- Each cycle it chooses one of: user data byte, frame delimiter, idle comma, or clock-compensation (CC) symbol.
- It drives the encoder's data/ctrl inputs and owns the running-disparity register that closes the encoder's disparity loop.
- Provides link initialisation (comma burst), framing and periodic CC insertion for the Aurora 8b/10b lane.

Parameters:
INIT_LEN, 16, number of K28.5 symbols sent in INIT before IDLE (>=1)
CC_PERIOD, 5000, cycles between CC requests (>= CC_LEN+2)
CC_LEN, 4, consecutive K23.7 symbols per CC burst (>=1)

Ports:
clk_i  in  1  single clock
rst_i  in  1  one clock; reset is synchronous and active-high
link_en_i  in  1  lane enable; low forces OFF
s_tdata_i  in  8  user byte
s_tvalid_i  in  1  user byte valid
s_tlast_i  in  1  last byte of frame
s_tready_o  out  1  byte accepted when s_tvalid_i & s_tready_o
enc_data_o  out  8  to encoder data_i
enc_ctrl_o  out  1  to encoder ctrl_i (1 = K symbol)
enc_disp_o  out  1  to encoder disp_i (running disparity, 0 = negative)
enc_disp_i  in  1  from encoder disp_o (combinational)
busy_o  out  1  high in SOF/DATA/EOF, or in CC entered from DATA

Behaviour:
Symbols:
- IDLE K28.5 = 8'hBC
- SOF K27.7 = 8'hFB
- EOF K29.7 = 8'hFD
- CC K23.7 = 8'hF7
- All are sent with ctrl = 1; data bytes are sent with ctrl = 0.

Reset values:
- enc_data_o = 8'hBC, enc_ctrl_o = 1, enc_disp_o = 0, s_tready_o = 0, busy_o = 0.
- State OFF; all counters 0; cc_pend = 0.

Registering and latency:
- enc_data_o and enc_ctrl_o are registered. A symbol selected in cycle n appears on them in cycle n+1.
- A byte accepted in cycle n is presented in cycle n+1.
- Running disparity: rd_q <= enc_disp_i every cycle; enc_disp_o = rd_q.

States:
- OFF: emit BC; s_tready_o = 0. If link_en_i is high -> INIT.
- INIT: emit BC INIT_LEN times (init counter), then -> IDLE.
- IDLE:
  - cc_pend -> CC (return to IDLE).
  - else if s_tvalid_i -> SOF.
  - else emit BC.
- SOF: emit FB for one cycle -> DATA. No byte is accepted in this cycle.
- DATA: s_tready_o = !cc_pend.
  - On handshake: emit s_tdata_i; if s_tlast_i -> EOF.
  - If !s_tvalid_i: emit BC as a mid-frame idle; stay in DATA.
  - If cc_pend: -> CC (return to DATA).
- EOF: emit FD -> IDLE. A back-to-back frame gets SOF on the next cycle through IDLE.
- CC: emit F7 for CC_LEN cycles, clear cc_pend, then return to the saved state.
- link_en_i low in any state: -> OFF on the next cycle, with no EOF generated. An open frame is abandoned, and the upstream must flush.

CC timer:
- Free-running counter 0..CC_PERIOD-1. It counts only outside OFF and INIT.
- Wrap sets cc_pend. cc_pend is cleared on CC exit.
- A wrap during CC is held pending, not lost.

s_tready_o rules:
- Combinational from state and cc_pend.
- Never high outside DATA.
- In DATA it is low whenever cc_pend is set. This is checked in the same cycle that cc_pend sets, so CC preempts data.
- Simultaneous cc_pend and a new frame in IDLE: CC is sent first.

Reset mid-frame: all outputs return to reset values in the next cycle.

Optional Feature:
AURORA_TX_STATS_EN:
- Defined: adds output ports frame_cnt_o[15:0] (increments on EOF emitted) and cc_cnt_o[15:0] (increments on CC burst completion). Both wrap at 16'hFFFF -> 0 and are cleared by rst_i.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
Package aurora_8b10b_pkg holds:
- symbol constants K_IDLE, K_SOF, K_EOF, K_CC
- state enum tx_state_t (OFF, INIT, IDLE, SOF, DATA, EOF, CC)

Sub-module aurora_cc_timer:
- Owns the period counter and cc_pend.
- Inputs: run, clr.
- Output: pend.

Test Plan:
1. Reset with link_en_i = 0 -> enc_data_o = BC, enc_ctrl_o = 1, enc_disp_o = 0, s_tready_o = 0 indefinitely.
2. link_en_i rises, INIT_LEN = 16 -> exactly 16 BC in INIT, then IDLE BC. s_tready_o stays 0.
3. Frame 11, 22, 33 (tlast on 33), with no CC due -> enc_data_o sequence FB, 11, 22, 33, FD and ctrl 1, 0, 0, 0, 1, then BC.
4. CC_PERIOD = 20, CC_LEN = 4, long frame streaming -> s_tready_o drops for 4 cycles, four F7 with ctrl = 1 appear mid-frame, and data resumes with no byte lost or duplicated.
5. s_tvalid_i low for 2 cycles mid-frame -> two BC symbols between data bytes; busy_o stays 1.
6. Encoder loop through a reference encoder over 1000 random frames -> every 10b symbol is disparity-legal, and rd_q tracks encoder disp_o. rst_i asserted mid-frame -> reset values on the next cycle, then INIT resumes.
